// File: rtl/ha_response_checker.sv
// Response checker for a half adder under test: it compares each sampled {a,b,sum,carry}
// against a^b / a&b, counts passes and errors, records the first failure and tracks coverage.
module ha_response_checker #(
   parameter int NUM_VECTORS = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             sum,
   input  logic             carry,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             first_err_valid,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [3:0]       first_err_vec,
   output logic [3:0]       cov_mask,
   output logic             pass
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] sample_cnt;

   logic             accept;
   logic             mismatch;
   logic             last_sample;
   logic [1:0]       vec_idx;
   logic [3:0]       cov_next;
   logic [CNT_W-1:0] err_next;
   logic [CNT_W-1:0] pass_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      accept      = (state == S_RUN) && in_valid;
      mismatch    = (sum != (a ^ b)) || (carry != (a & b));
      last_sample = (sample_cnt == LAST_IDX);
      vec_idx     = {a, b};
      cov_next    = cov_mask | (4'b0001 << vec_idx);
      err_next    = mismatch ? sat_inc(err_cnt) : err_cnt;
      pass_next   = mismatch ? pass_cnt : sat_inc(pass_cnt);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         sample_cnt      <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass_cnt        <= '0;
         err_cnt         <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_vec   <= 4'h0;
         cov_mask        <= 4'h0;
         pass            <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // A vector presented alongside start is deliberately not counted.
               if (start) begin
                  state           <= S_RUN;
                  sample_cnt      <= '0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass_cnt        <= '0;
                  err_cnt         <= '0;
                  first_err_valid <= 1'b0;
                  first_err_idx   <= '0;
                  first_err_vec   <= 4'h0;
                  cov_mask        <= 4'h0;
                  pass            <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  sample_cnt <= sat_inc(sample_cnt);
                  pass_cnt   <= pass_next;
                  err_cnt    <= err_next;
                  cov_mask   <= cov_next;
                  if (mismatch && !first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_idx   <= sample_cnt;
                     first_err_vec   <= {a, b, sum, carry};
                  end
                  // Verdict uses the post-update values so it lands with done.
                  if (last_sample) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0) && (cov_next == 4'hF);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ha_response_checker.sv
// Directed bench for ha_response_checker: stimulus pushes the expected end-of-run result,
// a monitor pops and compares it whenever done rises.
module tb_ha_response_checker;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n, start, in_valid, a, b, sum, carry;
   logic             busy, done, first_err_valid, pass;
   logic [CNT_W-1:0] pass_cnt, err_cnt, first_err_idx;
   logic [3:0]       first_err_vec, cov_mask;

   typedef struct {
      int         pass_cnt;
      int         err_cnt;
      logic       fev;
      int         fei;
      logic [3:0] fevec;
      logic [3:0] cov;
      logic       pass;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic prev_done = 1'b0;

   // Each nibble is {a,b,sum,carry}, sample 0 in the top nibble.
   localparam logic [15:0] GOLDEN = 16'h06AD;
   localparam logic [15:0] FAULTY = 16'h04AC;
   localparam logic [15:0] HOLE   = 16'h6666;

   ha_response_checker #(.NUM_VECTORS(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .sum(sum), .carry(carry),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
      .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
      .first_err_vec(first_err_vec), .cov_mask(cov_mask), .pass(pass)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic vld);
      {a, b, sum, carry} = v;
      in_valid = vld;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [15:0] vecs);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] v;
         v = vecs[15-4*i -: 4];
         drive(v, 1'b1);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      if (!done) check({name, "_timeout"}, 0, 1);
      tick();
   endtask

   task automatic push(input int pc, input int ec, input logic fev, input int fei,
                       input logic [3:0] fevec, input logic [3:0] cov, input logic p);
      exp_t e;
      e.pass_cnt = pc; e.err_cnt = ec; e.fev = fev; e.fei = fei;
      e.fevec = fevec; e.cov = cov; e.pass = p;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass_cnt"}, pass_cnt, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
      check({tag, "_fev"}, first_err_valid, 0);
      check({tag, "_fei"}, first_err_idx, 0);
      check({tag, "_fevec"}, first_err_vec, 0);
      check({tag, "_cov"}, cov_mask, 0);
      check({tag, "_pass"}, pass, 0);
   endtask

   // Monitor: compare the queued expectation on each rising edge of done.
   always @(negedge clk) begin
      if (done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_pass_cnt", pass_cnt, e.pass_cnt);
            check("mon_err_cnt", err_cnt, e.err_cnt);
            check("mon_fev", first_err_valid, e.fev);
            check("mon_fei", first_err_idx, e.fei);
            check("mon_fevec", first_err_vec, e.fevec);
            check("mon_cov", cov_mask, e.cov);
            check("mon_pass", pass, e.pass);
            check("mon_busy", busy, 0);
         end
      end
      prev_done <= done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      a = 1'b0; b = 1'b0; sum = 1'b0; carry = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      check_all_zero("reset");

      // Golden sweep
      pulse_start();
      check("golden_busy", busy, 1);
      push(4, 0, 0, 0, 4'h0, 4'hF, 1);
      feed(GOLDEN);
      wait_done("golden");

      // Injected faults, re-armed from DONE
      pulse_start();
      push(2, 2, 1, 1, 4'b0100, 4'hF, 0);
      feed(FAULTY);
      wait_done("faulty");

      // Coverage hole
      pulse_start();
      push(4, 0, 0, 0, 4'h0, 4'b0010, 0);
      feed(HOLE);
      wait_done("hole");

      // Stall / ignore: vectors in DONE ignored, stalls and start in RUN ignored
      drive(4'b0011, 1'b1);
      drive(4'b0011, 1'b1);
      in_valid = 1'b0;
      check("done_ignore_err", err_cnt, 0);
      check("done_ignore_pass", pass_cnt, 4);
      pulse_start();
      push(4, 0, 0, 0, 4'h0, 4'hF, 1);
      drive(4'b0000, 1'b1);
      drive(4'b0110, 1'b1);
      drive(4'b1111, 1'b0);
      start = 1'b1;
      drive(4'b1111, 1'b0);
      start = 1'b0;
      drive(4'b1111, 1'b0);
      check("stall_pass_cnt", pass_cnt, 2);
      check("stall_err_cnt", err_cnt, 0);
      check("stall_busy", busy, 1);
      start = 1'b1;
      drive(4'b1010, 1'b1);
      start = 1'b0;
      drive(4'b1101, 1'b1);
      in_valid = 1'b0;
      wait_done("stall");
      drive(4'b0011, 1'b1);
      drive(4'b0011, 1'b1);
      in_valid = 1'b0;
      check("post_done_pass_cnt", pass_cnt, 4);
      check("post_done_err_cnt", err_cnt, 0);

      // Reset mid-run
      pulse_start();
      drive(4'b0000, 1'b1);
      drive(4'b0100, 1'b1);
      in_valid = 1'b0;
      check("midrun_err_cnt", err_cnt, 1);
      check("midrun_pass_cnt", pass_cnt, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_all_zero("midrun_reset");
      drive(4'b0011, 1'b1);
      in_valid = 1'b0;
      check("idle_ignore_err", err_cnt, 0);
      check("idle_ignore_busy", busy, 0);
      pulse_start();
      push(4, 0, 0, 0, 4'h0, 4'hF, 1);
      feed(GOLDEN);
      wait_done("after_reset");

      // Re-arm with start and in_valid together
      pulse_start();
      push(2, 2, 1, 1, 4'b0100, 4'hF, 0);
      feed(FAULTY);
      wait_done("rearm_pre");
      check("rearm_pre_err", err_cnt, 2);
      start = 1'b1;
      drive(4'b0011, 1'b1);
      start = 1'b0;
      check("rearm_err_clear", err_cnt, 0);
      check("rearm_pass_clear", pass_cnt, 0);
      check("rearm_busy", busy, 1);
      push(4, 0, 0, 0, 4'h0, 4'hF, 1);
      feed(GOLDEN);
      wait_done("rearm");

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
